// File: rtl/avl_req_queue.sv
// avl_req_queue: request FIFO + Avalon issue stage with read throttling and registered read return; optional stats via AVL_REQ_QUEUE_STATS_EN
module avl_req_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int DEPTH      = 4,
  parameter int MAX_RD     = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [LINE_WIDTH-1:0]         req_wdata,
  input  logic [LINE_WIDTH/8-1:0]       req_be,
  input  logic                          avl_ready,
  output logic [ADDR_WIDTH-1:0]         avl_addr,
  output logic [LINE_WIDTH-1:0]         avl_wdata,
  output logic [LINE_WIDTH/8-1:0]       avl_be,
  output logic [2:0]                    avl_size,
  output logic                          avl_write_req,
  output logic                          avl_read_req,
  output logic                          avl_burstbegin,
  input  logic [LINE_WIDTH-1:0]         avl_rdata,
  input  logic                          avl_rdata_valid,
  output logic                          rsp_valid,
  output logic [LINE_WIDTH-1:0]         rsp_data,
  output logic [$clog2(MAX_RD+1)-1:0]   rd_outstanding,
  output logic                          idle,
`ifdef AVL_REQ_QUEUE_STATS_EN
  output logic [31:0]                   stat_rd,
  output logic [31:0]                   stat_wr,
  output logic [31:0]                   stat_stall,
`endif
  output logic                          err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(MAX_RD + 1);
  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_THROTTLE = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;
  logic                    q_rw   [DEPTH];
  logic [ADDR_WIDTH-1:0]   q_addr [DEPTH];
  logic [LINE_WIDTH-1:0]   q_wdata[DEPTH];
  logic [LINE_WIDTH/8-1:0] q_be   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic          head_rw, push, pop, rd_inc, rd_dec;
  // decode issue state from the FIFO head and the outstanding-read count
  always_comb begin
    head_rw = q_rw[rd_ptr];
    state   = (count == '0) ? S_EMPTY :
              (!head_rw && rd_outstanding == RW'(MAX_RD)) ? S_THROTTLE : S_ISSUE;
    req_ready      = count != CW'(DEPTH);
    push           = req_valid && req_ready;
    pop            = state == S_ISSUE && avl_ready;
    rd_inc         = pop && !head_rw;
    rd_dec         = avl_rdata_valid && rd_outstanding != '0;
    avl_write_req  = state == S_ISSUE && head_rw;
    avl_read_req   = state == S_ISSUE && !head_rw;
    avl_burstbegin = state == S_ISSUE;
    avl_addr       = q_addr[rd_ptr];
    avl_wdata      = q_wdata[rd_ptr];
    avl_be         = q_be[rd_ptr];
    avl_size       = 3'd1;
    idle           = count == '0 && rd_outstanding == '0;
  end
  // FIFO storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      q_rw[wr_ptr]    <= req_rw;
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
      q_be[wr_ptr]    <= req_be;
    end
  end
  // pointers, occupancy, outstanding reads, response register and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rd_outstanding <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      err            <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (rd_inc && !rd_dec) rd_outstanding <= rd_outstanding + RW'(1);
      else if (rd_dec && !rd_inc) rd_outstanding <= rd_outstanding - RW'(1);
      rsp_valid <= avl_rdata_valid;
      if (avl_rdata_valid) rsp_data <= avl_rdata;
      if (avl_rdata_valid && rd_outstanding == '0) err <= 1'b1;
    end
  end
`ifdef AVL_REQ_QUEUE_STATS_EN
  // saturating issue and stall counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd    <= '0;
      stat_wr    <= '0;
      stat_stall <= '0;
    end else begin
      if (rd_inc && stat_rd != '1) stat_rd <= stat_rd + 32'd1;
      if (pop && head_rw && stat_wr != '1) stat_wr <= stat_wr + 32'd1;
      if (state == S_ISSUE && !avl_ready && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_avl_req_queue.sv
// tb_avl_req_queue: directed self-checking bench for avl_req_queue (DEPTH=4, MAX_RD=2)
module tb_avl_req_queue;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, req_rw;
  logic [31:0]  req_addr;
  logic [255:0] req_wdata;
  logic [31:0]  req_be;
  logic         avl_ready;
  logic [31:0]  avl_addr;
  logic [255:0] avl_wdata;
  logic [31:0]  avl_be;
  logic [2:0]   avl_size;
  logic         avl_write_req, avl_read_req, avl_burstbegin;
  logic [255:0] avl_rdata;
  logic         avl_rdata_valid;
  logic         rsp_valid;
  logic [255:0] rsp_data;
  logic [1:0]   rd_outstanding;
  logic         idle, err;
`ifdef AVL_REQ_QUEUE_STATS_EN
  logic [31:0]  stat_rd, stat_wr, stat_stall;
`endif
  int total = 0;
  int bad = 0;

  avl_req_queue #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .DEPTH(4), .MAX_RD(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .avl_ready(avl_ready), .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_size(avl_size), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_burstbegin(avl_burstbegin), .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rd_outstanding(rd_outstanding),
    .idle(idle),
`ifdef AVL_REQ_QUEUE_STATS_EN
    .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_stall(stat_stall),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pat(input int k);
    logic [31:0] w;
    w = 32'hDEAD_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic push(input logic rw, input logic [31:0] a);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; avl_ready = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;
    step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_strobes", {avl_write_req, avl_read_req, avl_burstbegin}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rd_out", rd_outstanding, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    step();
    // single write
    avl_ready = 1'b1;
    req_wdata = {32{8'hA5}};
    req_be    = '1;
    push(1'b1, 32'h10);
    chk("wr_write_req", avl_write_req, 1);
    chk("wr_read_req", avl_read_req, 0);
    chk("wr_burstbegin", avl_burstbegin, 1);
    chk("wr_addr", avl_addr, 32'h10);
    chk("wr_size", avl_size, 1);
    chk("wr_wdata", avl_wdata, {32{8'hA5}});
    chk("wr_be", avl_be, 32'hFFFF_FFFF);
    step();
    chk("wr_idle", idle, 1);
    chk("wr_strobe_off", avl_write_req, 0);
    // full FIFO with stalled controller
    avl_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 32'h20 + 32'(i));
    chk("full_req_ready", req_ready, 0);
    push(1'b0, 32'h24);
    for (int i = 0; i < 20; i++) begin
      chk("hold_read_req", avl_read_req, 1);
      chk("hold_addr", avl_addr, 32'h20);
      chk("hold_req_ready", req_ready, 0);
      step();
    end
    // drain with returns overlapping issues from the second beat on
    avl_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_read_req", avl_read_req, 1);
      chk("drain_addr", avl_addr, 32'h20 + 32'(k));
      chk("drain_rd_out", rd_outstanding, (k == 0) ? 0 : 1);
      chk("drain_rsp_valid", rsp_valid, (k >= 2) ? 1 : 0);
      if (k >= 2) chk("drain_rsp_data", rsp_data, pat(k - 1));
      avl_rdata_valid = (k >= 1);
      avl_rdata       = pat(k);
      step();
    end
    chk("drain_empty", avl_read_req, 0);
    chk("drain_rsp_last", rsp_data, pat(3));
    chk("drain_rd_last", rd_outstanding, 1);
    avl_rdata_valid = 1'b1;
    avl_rdata       = pat(9);
    step();
    avl_rdata_valid = 1'b0;
    chk("drain_idle", idle, 1);
    chk("drain_err", err, 0);
    // read throttle at MAX_RD=2
    avl_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 32'h30 + 32'(i));
    avl_ready = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("thr_rd_out", rd_outstanding, 2);
      chk("thr_strobes", {avl_write_req, avl_read_req, avl_burstbegin}, 0);
      chk("thr_idle", idle, 0);
      step();
    end
    avl_rdata_valid = 1'b1;
    avl_rdata       = pat(16);
    step();
    avl_rdata_valid = 1'b0;
    chk("thr_release", avl_read_req, 1);
    chk("thr_release_addr", avl_addr, 32'h32);
    chk("thr_rd_after_ret", rd_outstanding, 1);
    chk("thr_rsp", rsp_data, pat(16));
    step();
    chk("thr_rd_full", rd_outstanding, 2);
    chk("thr_empty", avl_read_req, 0);
    avl_rdata_valid = 1'b1;
    step(); step();
    avl_rdata_valid = 1'b0;
    chk("thr_rd_zero", rd_outstanding, 0);
    chk("thr_err", err, 0);
    // stray return
    avl_rdata_valid = 1'b1;
    avl_rdata       = pat(32);
    step();
    avl_rdata_valid = 1'b0;
    chk("stray_err", err, 1);
    chk("stray_rsp_valid", rsp_valid, 1);
    chk("stray_rsp_data", rsp_data, pat(32));
    chk("stray_rd_out", rd_outstanding, 0);
    step();
    chk("stray_rsp_pulse", rsp_valid, 0);
    chk("stray_err_sticky", err, 1);
    // reset with queued entries
    avl_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b1, 32'h40 + 32'(i));
    chk("pre_rst_idle", idle, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_strobes", {avl_write_req, avl_read_req, avl_burstbegin}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_data}, 0);
    chk("mid_rst_rd_out", rd_outstanding, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_err", err, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", idle, 1);
    avl_rdata_valid = 1'b1;
    step();
    avl_rdata_valid = 1'b0;
    chk("post_rst_stray_err", err, 1);
`ifdef AVL_REQ_QUEUE_STATS_EN
    // stats: 2 writes, 2 reads queued with 4 stall cycles, then a 3rd read
    push(1'b1, 32'h50);
    push(1'b1, 32'h51);
    push(1'b0, 32'h52);
    push(1'b0, 32'h53);
    step();
    avl_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    avl_rdata_valid = 1'b1;
    step(); step();
    avl_rdata_valid = 1'b0;
    push(1'b0, 32'h54);
    step();
    chk("stat_wr", stat_wr, 2);
    chk("stat_rd", stat_rd, 3);
    chk("stat_stall", stat_stall, 4);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avl_req_queue.md
# avl_req_queue

Request queue and read-return stage sitting directly upstream of the DDR2 controller's Avalon port (`avl_*`). It accepts line-granular read/write requests from the cache/driver side, buffers them in a DEPTH-entry FIFO, and issues them one per accepted `avl_ready` handshake. It caps outstanding reads at MAX_RD and returns read lines on a registered response port.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, line address width; the byte address is `avl_addr` concatenated with `LINE_BITS` zeros.
- `LINE_WIDTH`, 256, data width of one line.
- `DEPTH`, 4, FIFO entries; must be a power of 2 and at least 2.
- `MAX_RD`, 4, maximum outstanding reads, at least 1.

Ports. Clock is `clk`; reset is `reset_n`, asynchronous and active-low.
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  async active-low reset.
- `req_valid` in 1, `req_ready` out 1: upstream handshake. A transfer occurs when both are high at a posedge.
- `req_rw`  in  1  1=write, 0=read.
- `req_addr`  in  ADDR_WIDTH  line address.
- `req_wdata`  in  LINE_WIDTH  write data.
- `req_be`  in  LINE_WIDTH/8  byte enables.
- `avl_ready`  in  1  controller accepts the current command.
- `avl_addr` out ADDR_WIDTH, `avl_wdata` out LINE_WIDTH, `avl_be` out LINE_WIDTH/8: head-entry fields.
- `avl_size`  out  3  constant 3'd1.
- `avl_write_req`, `avl_read_req`, `avl_burstbegin`  out  1  command strobes.
- `avl_rdata` in LINE_WIDTH, `avl_rdata_valid` in 1: read return.
- `rsp_valid` out 1, `rsp_data` out LINE_WIDTH: registered read response with no backpressure.
- `rd_outstanding`  out  $clog2(MAX_RD+1)  count of issued reads not yet returned.
- `idle`  out  1  FIFO empty and `rd_outstanding`==0.
- `err`  out  1  sticky; set by `avl_rdata_valid` while `rd_outstanding`==0.

## Operation
- **FIFO**: a push/pop pointer pair with a count of 0..DEPTH. `req_ready` = (count != DEPTH). A push while full is refused even if a pop happens in the same cycle. Push and pop in the same cycle at 0 < count < DEPTH leave count unchanged. Pointers wrap modulo DEPTH.
- **Issue FSM**, with the state decoded combinationally each cycle:
  - EMPTY: count==0. All strobes are low.
  - THROTTLE: the head is a read and `rd_outstanding`==MAX_RD. All strobes are low.
  - ISSUE: otherwise. `avl_write_req` = head.rw, `avl_read_req` = ~head.rw, `avl_burstbegin` = 1.
- **Holding rule**: in ISSUE, the strobe, address, data and byte enables stay stable until a posedge with `avl_ready`=1. That posedge pops the head. The next entry is presented in the following cycle with no bubble. Back-to-back issues are therefore one per cycle while `avl_ready` is high.
- **Read counter**:
  - +1 on a read issue.
  - −1 on `avl_rdata_valid` when the count is greater than 0.
  - Both in the same cycle leaves the count unchanged.
  - It never exceeds MAX_RD and never goes below 0.
- **Responses**: `rsp_valid` <= `avl_rdata_valid`. `rsp_data` <= `avl_rdata` whenever `avl_rdata_valid` is high, and holds otherwise. Responses return in controller order.
- **Stray return**: `avl_rdata_valid` while `rd_outstanding`==0 sets `err`, still produces `rsp_valid`, and leaves the counter at 0.

## Timing
- **Reset values**: count=0, pointers=0, `req_ready`=1, all `avl_*_req`/`avl_burstbegin`=0, `rsp_valid`=0, `rsp_data`=0, `rd_outstanding`=0, `idle`=1, `err`=0.
- **Reset mid-operation**: queued entries and the outstanding count are discarded. Returns that arrive afterwards set `err`.
- **Request latency**: a request pushed into an empty FIFO at posedge N presents its strobe during cycle N+1. It is popped at the first posedge ≥ N+1 with `avl_ready`=1.
- **Response latency**: `avl_rdata_valid` sampled at posedge N gives `rsp_valid` high during cycle N+1 for exactly one cycle per beat.
- The FIFO storage contains no combinational path from `req_*` to `avl_*`. `avl_*` are driven from the head entry.

## Configuration
- `AVL_REQ_QUEUE_STATS_EN`: when defined, the block adds three 32-bit outputs, each saturating at 32'hFFFF_FFFF and reset to 0:
  - `stat_rd`: count of reads issued.
  - `stat_wr`: count of writes issued.
  - `stat_stall`: cycles with a strobe high and `avl_ready`=0.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- **Single write**: `reset_n` deasserts. One write is pushed (addr 0x10, wdata all 0xA5, be all 1s) with `avl_ready`=1. Next cycle: `avl_write_req`=1, `avl_burstbegin`=1, `avl_addr`=0x10, `avl_size`=1. The cycle after, `idle`=1.
- **Full FIFO**: `avl_ready` is held 0 and 5 reads are pushed with DEPTH=4. `req_ready` goes 0 after the 4th push and the 5th is refused. The head read stays stable for 20 cycles. Releasing `avl_ready` gives 4 consecutive cycles of `avl_read_req`.
- **Read throttle**: MAX_RD=2, 3 reads are queued, `avl_ready`=1 and there are no returns. After 2 issues `rd_outstanding`=2 and the strobes are low (THROTTLE). One `avl_rdata_valid` releases the 3rd read on the next cycle.
- **Simultaneous issue and return**: a read issue and an `avl_rdata_valid` occur in the same cycle. `rd_outstanding` is unchanged, and `rsp_valid` pulses the next cycle with the returned data (0xDEAD… pattern).
- **Stray return and reset**: `avl_rdata_valid` with `rd_outstanding`=0 gives `err`=1 and a `rsp_valid` pulse. `reset_n` is pulsed low with 3 entries queued. All outputs return to reset values and `err`=0.
- **Stats** (with `AVL_REQ_QUEUE_STATS_EN`): 2 writes and 3 reads are issued, with `avl_ready` low for 4 cycles of the head strobe. Result: `stat_wr`=2, `stat_rd`=3, `stat_stall`=4.
